// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder/decoder datapath: LTE code
// polynomials, block-size limit and the constituent-encoder FSM states.
package turbo_pkg;

    // LTE constituent code: feedback 1+D^2+D^3, feedforward 1+D+D^3 (bit k = D^k)
    localparam logic [3:0] LTE_G_FB  = 4'b1101;
    localparam logic [3:0] LTE_G_FF  = 4'b1011;
    localparam int         LTE_M     = 3;
    localparam int         LTE_MAX_K = 6144;

    // Constituent encoder block FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TERM = 2'd2
    } rsc_fsm_e;

    // XOR of the taps of a polynomial against a tap vector (bit k = coeff of D^k)
    function automatic logic poly_tap_xor(input logic [7:0] poly, input logic [7:0] taps);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            acc = acc ^ (poly[k] & taps[k]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of an RSC trellis. State vector holds d_1..d_M with
// d_1 in the MSB. With force_term set, the input is replaced by the feedback
// value so that w becomes 0 and the register drains towards the zero state.
module rsc_trellis_step
    import turbo_pkg::*;
#(
    parameter int         M    = 3,
    parameter logic [M:0] G_FB = LTE_G_FB,
    parameter logic [M:0] G_FF = LTE_G_FF
) (
    input  logic [M-1:0] state,
    input  logic         u,
    input  logic         force_term,
    output logic         w,
    output logic         par,
    output logic         u_eff,
    output logic [M-1:0] next_state
);

    logic [7:0] taps;     // bit k = d_k, bit 0 = w
    logic [7:0] fb_poly;  // feedback taps without the D^0 term
    logic [7:0] ff_poly;
    logic       fb;

    // Feedback, effective input, recursion bit, parity and shifted state
    always_comb begin
        taps    = 8'd0;
        fb_poly = 8'd0;
        ff_poly = 8'd0;
        for (int k = 1; k <= M; k++) begin
            taps[k]    = state[M-k];
            fb_poly[k] = G_FB[k];
        end
        for (int k = 0; k <= M; k++) begin
            ff_poly[k] = G_FF[k];
        end
        fb = poly_tap_xor(fb_poly, taps);
        if (force_term) begin
            u_eff = fb;
        end else begin
            u_eff = u;
        end
        w          = u_eff ^ fb;
        taps[0]    = w;
        par        = poly_tap_xor(ff_poly, taps);
        next_state = {w, state[M-1:1]};
    end

endmodule

// File: rtl/rsc_encoder_param.sv
// Parametrised RSC constituent encoder with block framing, optional trellis
// termination (M tail beats) and valid/ready handshakes on both sides. One
// registered output stage gives 1-cycle latency at 1 beat/cycle throughput.
module rsc_encoder_param
    import turbo_pkg::*;
#(
    parameter int         M     = 3,
    parameter logic [M:0] G_FB  = LTE_G_FB,
    parameter logic [M:0] G_FF  = LTE_G_FF,
    parameter int         LEN_W = 13
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             term_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             u,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sys,
    output logic             par,
    output logic             term,
    output logic             last,
    output logic             busy,
    output logic             len_err,
    output logic [M-1:0]     state
);

    localparam int TW = $clog2(M + 1);

    rsc_fsm_e         fsm;
    rsc_fsm_e         fsm_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             term_en_q;
    logic [TW-1:0]    tail_cnt;
    logic [M-1:0]     trel;

    logic             out_free;
    logic             data_acc;
    logic             tail_acc;
    logic             cnt_last;
    logic             tail_last;
    logic             start_ok;
    logic             load;
    logic             beat_last;

    logic             step_w;
    logic             step_par;
    logic             step_u;
    logic [M-1:0]     step_next;
    // w is the MSB of next_state; the port exists for the decoder's reuse
    logic             unused_w;

    rsc_trellis_step #(
        .M    (M),
        .G_FB (G_FB),
        .G_FF (G_FF)
    ) u_step (
        .state      (trel),
        .u          (u),
        .force_term (fsm == TERM),
        .w          (step_w),
        .par        (step_par),
        .u_eff      (step_u),
        .next_state (step_next)
    );

    assign unused_w  = step_w;

    // The output slot is free when empty or being unloaded this cycle
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (fsm == DATA) && out_free;
    assign data_acc  = (fsm == DATA) && in_valid && out_free;
    assign tail_acc  = (fsm == TERM) && out_free;
    assign cnt_last  = ((cnt + LEN_W'(1)) == len_q);
    assign tail_last = (tail_cnt == TW'(M - 1));
    assign start_ok  = start && (blk_len != '0);
    assign busy      = (fsm != IDLE);
    assign state     = trel;

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic: IDLE -> DATA -> (TERM) -> IDLE
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: begin
                if (start_ok) begin
                    fsm_nxt = DATA;
                end else begin
                    fsm_nxt = IDLE;
                end
            end
            DATA: begin
                if (data_acc && cnt_last) begin
                    if (term_en_q) begin
                        fsm_nxt = TERM;
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end else begin
                    fsm_nxt = DATA;
                end
            end
            TERM: begin
                if (tail_acc && tail_last) begin
                    fsm_nxt = IDLE;
                end else begin
                    fsm_nxt = TERM;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Output-stage load strobe and the last flag of the beat being loaded
    always_comb begin
        load      = 1'b0;
        beat_last = 1'b0;
        case (fsm)
            IDLE: begin
                load      = 1'b0;
                beat_last = 1'b0;
            end
            DATA: begin
                load      = data_acc;
                beat_last = cnt_last && !term_en_q;
            end
            TERM: begin
                load      = tail_acc;
                beat_last = tail_last;
            end
            default: begin
                load      = 1'b0;
                beat_last = 1'b0;
            end
        endcase
    end

    // Block context, bit/tail counters and trellis register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            len_q     <= '0;
            term_en_q <= 1'b0;
            cnt       <= '0;
            tail_cnt  <= '0;
            trel      <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start_ok) begin
                        len_q     <= blk_len;
                        term_en_q <= term_en;
                        cnt       <= '0;
                        tail_cnt  <= '0;
                        trel      <= '0;
                    end
                end
                DATA: begin
                    if (data_acc) begin
                        cnt  <= cnt + LEN_W'(1);
                        trel <= step_next;
                    end
                end
                TERM: begin
                    if (tail_acc) begin
                        tail_cnt <= tail_cnt + TW'(1);
                        trel     <= step_next;
                    end
                end
                default: begin
                    trel <= '0;
                end
            endcase
        end
    end

    // Single registered output stage; holds while stalled downstream
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid <= 1'b0;
            sys       <= 1'b0;
            par       <= 1'b0;
            term      <= 1'b0;
            last      <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            sys       <= step_u;
            par       <= step_par;
            term      <= (fsm == TERM);
            last      <= beat_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for a zero-length start request in IDLE
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            len_err <= 1'b0;
        end else begin
            len_err <= (fsm == IDLE) && start && (blk_len == '0);
        end
    end

endmodule
